// File: rtl/pixel_frame_sequencer_if.sv
// Pixel command stream from the frame sequencer to the WS2812B driver.
// The master (sequencer) offers a colour or latch command with valid;
// the slave (driver) accepts it with ready.
interface pixel_frame_sequencer_if;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       latch;
    logic       valid;
    logic       ready;

    modport master (output red, green, blue, latch, valid, input ready);
    modport slave  (input red, green, blue, latch, valid, output ready);
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Pixel frame sequencer: once per frame period it walks the framebuffer
// in address order, scales every colour by a global brightness and hands
// each pixel to the WS2812B driver, ending the frame with a latch command.
module pixel_frame_sequencer #(
    parameter int FRAME_TICKS = 200000,
    parameter int LED         = 256,
    parameter int ADDR_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [7:0]            brightness,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [23:0]           rd_data,
    pixel_frame_sequencer_if.master pix,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int                TIMER_W      = $clog2(FRAME_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(FRAME_TICKS - 1);
    localparam logic [ADDR_W-1:0]  LAST_INDEX   = ADDR_W'(LED - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PRESENT,
        LATCH
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TIMER_W-1:0]  timer;
    logic                tick;
    logic                pending;
    logic                start_frame;
    logic [ADDR_W-1:0]   index;
    logic [7:0]          brightness_q;
    logic [7:0]          red_q;
    logic [7:0]          green_q;
    logic [7:0]          blue_q;
    logic                valid_c;
    logic                latch_c;
    logic [7:0]          red_c;
    logic [7:0]          green_c;
    logic [7:0]          blue_c;

    // Scale one colour channel: (c * (b + 1)) >> 8, so b=255 is identity.
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] product;
        product = {8'd0, c} * ({8'd0, b} + 16'd1);
        return product[15:8];
    endfunction

    assign tick        = enable && (timer == '0);
    assign start_frame = (state == IDLE) && pending;

    // Frame period counter: ticks on the first enabled cycle, then every FRAME_TICKS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (!enable) begin
            timer <= '0;
        end else if (timer == '0) begin
            timer <= TIMER_RELOAD;
        end else begin
            timer <= timer - TIMER_W'(1);
        end
    end

    // One-deep frame request; a tick that finds it still set flags a sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (tick) begin
                pending <= 1'b1;
            end else if (start_frame) begin
                pending <= 1'b0;
            end
            if (tick && pending && !start_frame) begin
                overrun <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/read outputs for the frame walk.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        valid_c    = 1'b0;
        latch_c    = 1'b0;
        red_c      = 8'd0;
        green_c    = 8'd0;
        blue_c     = 8'd0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rd_en      = 1'b1;
                rd_addr    = index;
                state_next = LOAD;
            end
            LOAD: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                valid_c = 1'b1;
                red_c   = red_q;
                green_c = green_q;
                blue_c  = blue_q;
                if (pix.ready) begin
                    state_next = (index == LAST_INDEX) ? LATCH : FETCH;
                end
            end
            LATCH: begin
                valid_c = 1'b1;
                latch_c = 1'b1;
                if (pix.ready) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pixel index, per-frame brightness snapshot and scaled colour holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index        <= '0;
            brightness_q <= 8'd0;
            red_q        <= 8'd0;
            green_q      <= 8'd0;
            blue_q       <= 8'd0;
        end else begin
            if (start_frame) begin
                brightness_q <= brightness;
                index        <= '0;
            end
            if (state == LOAD) begin
                red_q   <= scale_channel(rd_data[23:16], brightness_q);
                green_q <= scale_channel(rd_data[15:8],  brightness_q);
                blue_q  <= scale_channel(rd_data[7:0],   brightness_q);
            end
            if ((state == PRESENT) && pix.ready && (index != LAST_INDEX)) begin
                index <= index + ADDR_W'(1);
            end
            if ((state == LATCH) && pix.ready) begin
                index <= '0;
            end
        end
    end

    assign pix.valid = valid_c;
    assign pix.latch = latch_c;
    assign pix.red   = red_c;
    assign pix.green = green_c;
    assign pix.blue  = blue_c;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Testbench for pixel_frame_sequencer: random framebuffer contents,
// brightness and driver back-pressure, checked against a frame-level
// model of the expected pixel/latch command stream.
module tb_pixel_frame_sequencer;

    localparam int FT   = 80;
    localparam int LEDN = 6;
    localparam int AW   = 3;
    localparam int FT1  = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          enable1;
    logic [7:0]    brightness;
    logic [7:0]    brightness1;
    logic          rd_en;
    logic          rd_en1;
    logic [AW-1:0] rd_addr;
    logic [0:0]    rd_addr1;
    logic [23:0]   rd_data;
    logic [23:0]   rd_data1;
    logic [23:0]   ram1_word;
    logic          busy;
    logic          busy1;
    logic          frame_done;
    logic          frame_done1;
    logic          overrun;
    logic          overrun1;
    logic [23:0]   ram [0:7];

    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [24:0]   obs_q[$];
    logic [24:0]   exp_q[$];
    int            addr_q[$];

    pixel_frame_sequencer_if pix ();
    pixel_frame_sequencer_if pix1 ();

    always #5 clk = ~clk;

    pixel_frame_sequencer #(.FRAME_TICKS(FT), .LED(LEDN), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .brightness (brightness),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pix        (pix),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    pixel_frame_sequencer #(.FRAME_TICKS(FT1), .LED(1), .ADDR_W(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable1),
        .brightness (brightness1),
        .rd_en      (rd_en1),
        .rd_addr    (rd_addr1),
        .rd_data    (rd_data1),
        .pix        (pix1),
        .busy       (busy1),
        .frame_done (frame_done1),
        .overrun    (overrun1)
    );

    // Synchronous framebuffer RAM models.
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];
    always @(posedge clk) if (rd_en1) rd_data1 <= ram1_word;

    // Record accepted commands, read addresses and frame_done pulses.
    always @(negedge clk) begin
        #1;
        if (reset_n === 1'b1) begin
            if (pix.valid && pix.ready)
                obs_q.push_back({pix.latch, pix.red, pix.green, pix.blue});
            if (rd_en) addr_q.push_back(int'(rd_addr));
            if (frame_done) done_cnt++;
        end
    end

    function automatic logic [7:0] scale_ref(input logic [7:0] c, input logic [7:0] b);
        int v;
        v = (int'(c) * (int'(b) + 1)) / 256;
        return v[7:0];
    endfunction

    // Expected stream: LEDN scaled pixels followed by one latch, per frame.
    task automatic build_expected(input logic [7:0] b, input int frames);
        exp_q.delete();
        repeat (frames) begin
            for (int i = 0; i < LEDN; i++)
                exp_q.push_back({1'b0, scale_ref(ram[i][23:16], b),
                                 scale_ref(ram[i][15:8], b), scale_ref(ram[i][7:0], b)});
            exp_q.push_back({1'b1, 24'd0});
        end
    endtask

    task automatic fill_ram_random();
        for (int i = 0; i < 8; i++) ram[i] = 24'($urandom());
    endtask

    task automatic cycle(input logic rdy);
        @(negedge clk);
        pix.ready = rdy;
        #2;
    endtask

    task automatic quiesce();
        @(negedge clk);
        enable = 1'b0;
        pix.ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        addr_q.delete();
        done_cnt = 0;
        #2;
    endtask

    task automatic run_until_done(input int target, input bit rand_ready, input string name);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            cycle(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("[TB] FAIL %s_timeout: frame_done count %0d, required %0d", name, done_cnt, target);
        end
    endtask

    // Reset drives every output low.
    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        enable1 = 1'b0;
        brightness = 8'd0;
        brightness1 = 8'd0;
        ram1_word = 24'd0;
        pix.ready = 1'b0;
        pix1.ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, pix.red, pix.green, pix.blue, pix.latch, pix.valid,
             busy, frame_done, overrun} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b busy=%b rd_en=%b overrun=%b rgb=%h, required all 0",
                     pix.valid, busy, rd_en, overrun, {pix.red, pix.green, pix.blue});
        end
        checks++;
        if ({busy1, overrun1, pix1.valid, rd_en1} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs_led1: got %b, required 0000", {busy1, overrun1, pix1.valid, rd_en1});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Full-brightness frame with ready tied high: latency, address order, stream.
    task automatic test_main_frame();
        quiesce();
        for (int i = 0; i < 8; i++) ram[i] = 24'h102030 + 24'(i);
        brightness = 8'd255;
        build_expected(8'd255, 1);
        @(negedge clk);
        enable = 1'b1;
        pix.ready = 1'b1;
        #2;
        cycle(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL main_tick_cycle_busy: got %b, required 0", busy);
        end
        cycle(1'b1);
        checks++;
        if ({busy, rd_en, rd_addr} !== {1'b1, 1'b1, {AW{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL main_first_fetch: got busy/rd_en/addr %b/%b/%0d, required 1/1/0", busy, rd_en, rd_addr);
        end
        cycle(1'b1);
        checks++;
        if (pix.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL main_load_valid: got %b, required 0", pix.valid);
        end
        cycle(1'b1);
        checks++;
        if ({pix.valid, pix.latch, pix.red, pix.green, pix.blue} !== {1'b1, 1'b0, 24'h102030}) begin
            failures++;
            $display("[TB] FAIL main_first_pixel: got v=%b l=%b rgb=%h, required v=1 l=0 rgb=102030",
                     pix.valid, pix.latch, {pix.red, pix.green, pix.blue});
        end
        run_until_done(1, 1'b0, "main");
        enable = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL main_stream_len: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL main_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (addr_q.size() != LEDN) begin
            failures++;
            $display("[TB] FAIL main_addr_count: got %0d reads, required %0d", addr_q.size(), LEDN);
        end else foreach (addr_q[i]) begin
            checks++;
            if (addr_q[i] != i) begin
                failures++;
                $display("[TB] FAIL main_addr[%0d]: got %0d, required %0d", i, addr_q[i], i);
            end
        end
        repeat (3) cycle(1'b1);
        checks++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            failures++;
            $display("[TB] FAIL main_after_frame: got busy=%b done=%0d, required busy=0 done=1", busy, done_cnt);
        end
    endtask

    // Driver stalls for 50 cycles while a pixel is presented.
    task automatic test_hold();
        logic [24:0] held;
        int          n = 0;
        int          bad = 0;
        quiesce();
        fill_ram_random();
        brightness = 8'($urandom());
        build_expected(brightness, 1);
        @(negedge clk);
        enable = 1'b1;
        pix.ready = 1'b0;
        #2;
        while (!pix.valid && n < 10) begin
            cycle(1'b0);
            n++;
        end
        held = {pix.latch, pix.red, pix.green, pix.blue};
        repeat (50) begin
            cycle(1'b0);
            if (pix.valid !== 1'b1 || {pix.latch, pix.red, pix.green, pix.blue} !== held ||
                rd_en !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL hold_stable: got %0d unstable cycles, required 0", bad);
        end
        checks++;
        if (addr_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL hold_no_advance: got %0d reads, required 1", addr_q.size());
        end
        checks++;
        if (held !== exp_q[0]) begin
            failures++;
            $display("[TB] FAIL hold_payload: got %h, required %h", held, exp_q[0]);
        end
        run_until_done(1, 1'b1, "hold");
        enable = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL hold_stream_len: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL hold_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Brightness scaling, sampling at frame start, and zero brightness.
    task automatic test_brightness();
        logic [24:0] first_exp;
        first_exp = {1'b0, 24'h804000};
        quiesce();
        fill_ram_random();
        ram[0] = 24'hFF8001;
        brightness = 8'd128;
        build_expected(8'd128, 1);
        @(negedge clk);
        enable = 1'b1;
        pix.ready = 1'b1;
        #2;
        cycle(1'b1);
        cycle(1'b1);
        brightness = 8'($urandom_range(0, 127));
        run_until_done(1, 1'b1, "bright");
        enable = 1'b0;
        checks++;
        if (obs_q.size() == 0 || obs_q[0] !== first_exp) begin
            failures++;
            $display("[TB] FAIL bright_128_pixel: got %h, required %h", obs_q.size() ? obs_q[0] : 25'h0, first_exp);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL bright_stream_len: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL bright_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        quiesce();
        fill_ram_random();
        brightness = 8'd0;
        build_expected(8'd0, 1);
        @(negedge clk);
        enable = 1'b1;
        #2;
        run_until_done(1, 1'b1, "bright0");
        enable = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL bright0_stream_len: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL bright0_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Several random frames under random back-pressure.
    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            quiesce();
            fill_ram_random();
            brightness = 8'($urandom());
            build_expected(brightness, 1);
            @(negedge clk);
            enable = 1'b1;
            #2;
            run_until_done(1, 1'b1, "random");
            enable = 1'b0;
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                failures++;
                $display("[TB] FAIL random%0d_stream_len: got %0d, required %0d", f, obs_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("[TB] FAIL random%0d_stream[%0d]: got %h, required %h", f, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // Ticks piling up behind a stalled frame: one queued frame, sticky overrun.
    task automatic test_overrun();
        quiesce();
        fill_ram_random();
        brightness = 8'($urandom());
        build_expected(brightness, 2);
        @(negedge clk);
        enable = 1'b1;
        pix.ready = 1'b0;
        #2;
        repeat (100) cycle(1'b0);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_early: got %b, required 0", overrun);
        end
        repeat (70) cycle(1'b0);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun_set: got %b, required 1", overrun);
        end
        enable = 1'b0;
        run_until_done(2, 1'b1, "overrun");
        repeat (100) cycle(1'($urandom_range(0, 1)));
        checks++;
        if (done_cnt != 2 || overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_frames: got done=%0d overrun=%b busy=%b, required 2/1/0", done_cnt, overrun, busy);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL overrun_stream_len: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL overrun_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Asynchronous reset while presenting, then a clean restart from index 0.
    task automatic test_reset_mid_frame();
        int n = 0;
        quiesce();
        fill_ram_random();
        brightness = 8'($urandom());
        @(negedge clk);
        enable = 1'b1;
        pix.ready = 1'b0;
        #2;
        while (!pix.valid && n < 10) begin
            cycle(1'b0);
            n++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pix.valid, rd_en, busy, pix.latch, pix.red, pix.green, pix.blue} !== '0) begin
            failures++;
            $display("[TB] FAIL rstmid_async: got valid=%b rd_en=%b busy=%b latch=%b, required all 0",
                     pix.valid, rd_en, busy, pix.latch);
        end
        @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        addr_q.delete();
        done_cnt = 0;
        build_expected(brightness, 1);
        #2;
        run_until_done(1, 1'b1, "rstmid");
        enable = 1'b0;
        checks++;
        if (addr_q.size() == 0 || addr_q[0] != 0) begin
            failures++;
            $display("[TB] FAIL rstmid_first_addr: got %0d, required 0", addr_q.size() ? addr_q[0] : -1);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL rstmid_stream_len: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL rstmid_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Enable dropped mid-frame: frame completes, no more ticks, re-enable ticks at once.
    task automatic test_enable_drop();
        int   busy_seen = 0;
        logic b0;
        logic b1;
        quiesce();
        fill_ram_random();
        brightness = 8'($urandom());
        build_expected(brightness, 1);
        @(negedge clk);
        enable = 1'b1;
        pix.ready = 1'b1;
        #2;
        cycle(1'b1);
        cycle(1'b1);
        enable = 1'b0;
        run_until_done(1, 1'b1, "endrop");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL endrop_stream_len: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL endrop_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        repeat (2 * FT) begin
            cycle(1'b1);
            if (busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || done_cnt != 1) begin
            failures++;
            $display("[TB] FAIL endrop_no_ticks: got busy cycles=%0d done=%0d, required 0/1", busy_seen, done_cnt);
        end
        @(negedge clk);
        enable = 1'b1;
        #2;
        cycle(1'b1);
        b0 = busy;
        cycle(1'b1);
        b1 = busy;
        checks++;
        if ({b0, b1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL endrop_reenable_tick: got busy sequence %b, required 01", {b0, b1});
        end
        enable = 1'b0;
        run_until_done(2, 1'b0, "endrop_reenable");
    endtask

    // Single-LED configuration: one pixel followed directly by the latch.
    task automatic test_single_led();
        logic [24:0] got[$];
        logic [24:0] exp0;
        int          n = 0;
        int          addr_bad = 0;
        bit          done = 1'b0;
        quiesce();
        ram1_word = 24'($urandom());
        brightness1 = 8'($urandom());
        exp0 = {1'b0, scale_ref(ram1_word[23:16], brightness1),
                scale_ref(ram1_word[15:8], brightness1), scale_ref(ram1_word[7:0], brightness1)};
        @(negedge clk);
        enable1 = 1'b1;
        while (!done && n < 30) begin
            @(negedge clk);
            #1;
            if (pix1.valid && pix1.ready) got.push_back({pix1.latch, pix1.red, pix1.green, pix1.blue});
            if (rd_en1 && rd_addr1 !== 1'b0) addr_bad++;
            if (frame_done1) done = 1'b1;
            n++;
        end
        enable1 = 1'b0;
        checks++;
        if (got.size() != 2 || addr_bad != 0) begin
            failures++;
            $display("[TB] FAIL led1_count: got %0d transfers (bad addr %0d), required 2", got.size(), addr_bad);
        end else begin
            checks++;
            if (got[0] !== exp0) begin
                failures++;
                $display("[TB] FAIL led1_pixel: got %h, required %h", got[0], exp0);
            end
            checks++;
            if (got[1] !== {1'b1, 24'd0}) begin
                failures++;
                $display("[TB] FAIL led1_latch: got %h, required %h", got[1], {1'b1, 24'd0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_main_frame();
        test_hold();
        test_brightness();
        test_random_frames();
        test_overrun();
        test_reset_mid_frame();
        test_enable_drop();
        test_single_led();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
